imem_loader: RTL and testbench

Boot-time program loader and instruction-memory server for the 5-stage MIPS core. It accepts a framed byte stream, assembles big-endian 32-bit words and writes them into an internal instruction array. It holds the core in reset until the frame completes, then serves the core's word-addressed fetch requests combinationally from that array.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_array.sv | 28 ++
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the boot-time instruction loader.
//   state_t   : loader FSM states
//   SYNC_BYTE : frame start marker
//   LEN_W     : width of the frame word-count field
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEN_H = 3'd1,
      LEN_L = 3'd2,
      DATA  = 3'd3,
      CSUM  = 3'd4,
      DONE  = 3'd5,
      ERR   = 3'd6
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int unsigned LEN_W = 16;

endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x 32 instruction storage. Not reset, so contents survive rst_n.
//   clk   : clock
//   we    : write enable (synchronous write)
//   waddr : write word address
//   wdata : write data
//   raddr : read word address
//   rdata : combinational read data (a same-cycle write is not visible until after the edge)
module imem_array #(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (A5, LEN_HI, LEN_LO, 4*N data bytes
// big-endian, optional CSUM), writes the words into an instruction array, holds the
// core in reset until the frame completes, then serves combinational fetches.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum
// byte over LEN and data bytes.
//   clk, rst_n   : clock, synchronous active-low reset
//   s_valid/s_data/s_ready : byte stream handshake
//   reload       : pulse in DONE/ERR returns to IDLE
//   fetch_addr   : word address from the core
//   fetch_instr  : instruction at fetch_addr (combinational)
//   cpu_rst_n    : core reset, released only in DONE
//   load_done / load_err : status flags
//   words_loaded : words written in the current frame
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   input  logic              reload,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [31:0]       fetch_instr,
   output logic              cpu_rst_n,
   output logic              load_done,
   output logic              load_err,
   output logic [15:0]       words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t AFTER_DATA = CSUM;
`else
   localparam state_t AFTER_DATA = DONE;
`endif

   state_t            state, state_next;
   logic              xfer;
   logic [7:0]        len_hi;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  len_full;
   logic [1:0]        b;
   // Only three bytes need holding; the fourth is taken straight from s_data at the write edge.
   logic [23:0]       asm_word;
   logic              we;
   logic [31:0]       wdata;
   logic              sync_seen;
   logic              last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   assign s_ready   = (state == IDLE) || (state == LEN_H) || (state == LEN_L) ||
                      (state == DATA) || (state == CSUM);
   assign xfer      = s_valid && s_ready;
   assign sync_seen = (state == IDLE) && xfer && (s_data == SYNC_BYTE);
   assign len_full  = {len_hi, s_data};
   assign we        = (state == DATA) && xfer && (b == 2'd3);
   assign wdata     = {asm_word, s_data};
   assign last_word = (words_loaded + 16'd1) == len;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (sync_seen) state_next = LEN_H;
         LEN_H: if (xfer) state_next = LEN_L;
         LEN_L: begin
            if (xfer) begin
               if (len_full > LEN_W'(DEPTH)) state_next = ERR;
               else if (len_full == '0)      state_next = AFTER_DATA;
               else                          state_next = DATA;
            end
         end
         DATA:  if (we && last_word) state_next = AFTER_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM:  if (xfer) state_next = (s_data == csum) ? DONE : ERR;
`else
         CSUM:  state_next = IDLE;
`endif
         DONE:  if (reload) state_next = IDLE;
         ERR:   if (reload) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cpu_rst_n <= 1'b0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         state     <= state_next;
         cpu_rst_n <= (state_next == DONE);
         load_done <= (state_next == DONE);
         load_err  <= (state_next == ERR);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         words_loaded <= '0;
         b            <= '0;
         asm_word     <= '0;
         len_hi       <= '0;
         len          <= '0;
      end else begin
         if (sync_seen) begin
            words_loaded <= '0;
            b            <= '0;
         end else if (((state == DONE) || (state == ERR)) && reload) begin
            words_loaded <= '0;
         end else if (we) begin
            words_loaded <= words_loaded + 16'd1;
         end
         if ((state == DATA) && xfer) begin
            b        <= b + 2'd1;
            asm_word <= {asm_word[15:0], s_data};
         end
         if ((state == LEN_H) && xfer) len_hi <= s_data;
         if ((state == LEN_L) && xfer) len    <= len_full;
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         csum <= '0;
      end else if (sync_seen) begin
         csum <= '0;
      end else if (xfer && ((state == LEN_H) || (state == LEN_L) || (state == DATA))) begin
         csum <= csum ^ s_data;
      end
   end
`endif

   imem_array #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .we    (we),
      .waddr (words_loaded[ADDR_W-1:0]),
      .wdata (wdata),
      .raddr (fetch_addr),
      .rdata (fetch_instr)
   );

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed, table-driven bench for imem_loader (DEPTH=64).
// Honours IMEM_LOADER_CHECKSUM_EN the same way as the design.
module tb_imem_loader;

   localparam int unsigned DEPTH  = 64;
   localparam int unsigned ADDR_W = 6;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              s_valid = 1'b0;
   logic [7:0]        s_data = '0;
   logic              s_ready;
   logic              reload = 1'b0;
   logic [ADDR_W-1:0] fetch_addr = '0;
   logic [31:0]       fetch_instr;
   logic              cpu_rst_n;
   logic              load_done;
   logic              load_err;
   logic [15:0]       words_loaded;

   int checks = 0;
   int failures = 0;

   imem_loader #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_ready      (s_ready),
      .reload       (reload),
      .fetch_addr   (fetch_addr),
      .fetch_instr  (fetch_instr),
      .cpu_rst_n    (cpu_rst_n),
      .load_done    (load_done),
      .load_err     (load_err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  data;
      logic        exp_ready;
      logic        exp_cpu;
      logic        exp_done;
      logic [15:0] exp_words;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_status(input string name, input logic rdy, input logic cpu,
                             input logic done, input logic err, input logic [15:0] words);
      chk({name, ".s_ready"},      32'(s_ready),      32'(rdy));
      chk({name, ".cpu_rst_n"},    32'(cpu_rst_n),    32'(cpu));
      chk({name, ".load_done"},    32'(load_done),    32'(done));
      chk({name, ".load_err"},     32'(load_err),     32'(err));
      chk({name, ".words_loaded"}, 32'(words_loaded), 32'(words));
   endtask

   task automatic step(input logic v, input logic [7:0] d);
      s_valid = v;
      s_data  = d;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic send(input logic [7:0] bytes[$]);
      foreach (bytes[i]) step(1'b1, bytes[i]);
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      @(posedge clk);
      #1;
      reload = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic fetch_chk(input string name, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
      fetch_addr = a;
      #1;
      chk(name, fetch_instr, exp);
   endtask

   initial begin
      // reset and idle hold
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_status("reset", 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 8'h00);
         chk("idle_hold.cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      end
      chk_status("idle_hold", 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);

      // main frame, one record per byte: status after the byte's edge
`ifdef IMEM_LOADER_CHECKSUM_EN
      vecs = '{
         '{8'h00, 1, 0, 0, 0}, '{8'hA5, 1, 0, 0, 0}, '{8'h00, 1, 0, 0, 0}, '{8'h02, 1, 0, 0, 0},
         '{8'h8C, 1, 0, 0, 0}, '{8'h01, 1, 0, 0, 0}, '{8'h00, 1, 0, 0, 0}, '{8'h00, 1, 0, 0, 1},
         '{8'hAC, 1, 0, 0, 1}, '{8'h03, 1, 0, 0, 1}, '{8'h00, 1, 0, 0, 1}, '{8'h03, 1, 0, 0, 2},
         '{8'h23, 0, 1, 1, 2}};
`else
      vecs = '{
         '{8'h00, 1, 0, 0, 0}, '{8'hA5, 1, 0, 0, 0}, '{8'h00, 1, 0, 0, 0}, '{8'h02, 1, 0, 0, 0},
         '{8'h8C, 1, 0, 0, 0}, '{8'h01, 1, 0, 0, 0}, '{8'h00, 1, 0, 0, 0}, '{8'h00, 1, 0, 0, 1},
         '{8'hAC, 1, 0, 0, 1}, '{8'h03, 1, 0, 0, 1}, '{8'h00, 1, 0, 0, 1}, '{8'h03, 0, 1, 1, 2}};
`endif
      foreach (vecs[i]) begin
         step(1'b1, vecs[i].data);
         chk_status($sformatf("frame[%0d]", i), vecs[i].exp_ready, vecs[i].exp_cpu,
                    vecs[i].exp_done, 1'b0, vecs[i].exp_words);
      end
      fetch_chk("frame.fetch0", 6'd0, 32'h8C010000);
      fetch_chk("frame.fetch1", 6'd1, 32'hAC030003);
      step(1'b1, 8'hA5);
      chk_status("done_ignores_bytes", 1'b0, 1'b1, 1'b1, 1'b0, 16'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // bad checksum, then recover with the good one
      pulse_reload();
      send('{8'hA5, 8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h00, 8'hAC, 8'h03, 8'h00, 8'h03, 8'h24});
      chk_status("bad_csum", 1'b0, 1'b0, 1'b0, 1'b1, 16'd2);
      pulse_reload();
      chk_status("bad_csum_reload", 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
      send('{8'hA5, 8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h00, 8'hAC, 8'h03, 8'h00, 8'h03, 8'h23});
      chk_status("good_csum", 1'b0, 1'b1, 1'b1, 1'b0, 16'd2);
`endif

      // length over DEPTH
      pulse_reload();
      chk_status("reload_idle", 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
      send('{8'hA5, 8'h00, 8'h41});
      chk_status("len_too_big", 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
      repeat (3) step(1'b0, 8'h00);
      chk_status("err_sticky", 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
      pulse_reload();
      chk_status("err_reload", 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);

      // s_valid toggling every other cycle
      begin
         logic [7:0] tb_bytes[$];
`ifdef IMEM_LOADER_CHECKSUM_EN
         tb_bytes = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h02};
`else
         tb_bytes = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
`endif
         foreach (tb_bytes[i]) begin
            step(1'b1, tb_bytes[i]);
            if (i != tb_bytes.size() - 1) step(1'b0, 8'hFF);
         end
      end
      chk_status("toggle", 1'b0, 1'b1, 1'b1, 1'b0, 16'd2);
      fetch_chk("toggle.fetch0", 6'd0, 32'h12345678);
      fetch_chk("toggle.fetch1", 6'd1, 32'h9ABCDEF0);

      // partial frame abandoned by rst_n, then a full 1-word frame
      pulse_reload();
      send('{8'hA5, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03});
      fetch_addr = 6'd0;
      s_valid = 1'b1;
      s_data  = 8'h04;
      #1;
      chk("same_cycle_read_old", fetch_instr, 32'h12345678);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      chk("write_visible_after_edge", fetch_instr, 32'h01020304);
      send('{8'h05, 8'h06});
      chk_status("partial", 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
      pulse_reset();
      chk_status("mid_frame_reset", 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send('{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45});
`else
      send('{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44});
`endif
      chk_status("one_word", 1'b0, 1'b1, 1'b1, 1'b0, 16'd1);
      fetch_chk("one_word.fetch0", 6'd0, 32'h11223344);
      fetch_chk("one_word.fetch1_retained", 6'd1, 32'h9ABCDEF0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
